// File: rtl/fir_result_quantizer_if.sv
// fir_result_quantizer_if: sample input, output FIFO handshake and status bus of the quantizer.
interface fir_result_quantizer_if #(
    parameter int IN_W       = 39,
    parameter int OUT_W      = 16,
    parameter int FIFO_DEPTH = 8
);
    logic                          i_ce;
    logic [IN_W-1:0]               i_result;
    logic                          i_ready;
    logic                          i_clear_status;
    logic [OUT_W-1:0]              o_data;
    logic                          o_valid;
    logic [$clog2(FIFO_DEPTH):0]   o_level;
    logic [15:0]                   o_sat_cnt;
    logic                          o_drop;
    modport master (
        output i_ce, i_result, i_ready, i_clear_status,
        input  o_data, o_valid, o_level, o_sat_cnt, o_drop
    );
    modport slave (
        input  i_ce, i_result, i_ready, i_clear_status,
        output o_data, o_valid, o_level, o_sat_cnt, o_drop
    );
endinterface

// File: rtl/fir_result_quantizer.sv
// fir_result_quantizer: rounds/rescales the FIR accumulator to OUT_W bits, saturates,
// and buffers samples in a valid/ready FIFO with saturation and drop status.
module fir_result_quantizer #(
    parameter int IN_W       = 39,
    parameter int OUT_W      = 16,
    parameter int SHIFT      = 15,
    parameter int FIFO_DEPTH = 8
) (
    input logic                   clk,
    input logic                   i_reset,
    fir_result_quantizer_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic signed [IN_W:0] RND  = (IN_W+1)'(1) << (SHIFT - 1);
    localparam logic signed [IN_W:0] MAXV = (IN_W+1)'(2**(OUT_W-1) - 1);
    localparam logic signed [IN_W:0] MINV = ~MAXV;

    logic                    v1_q, v2_q, sat2_q, drop_q;
    logic signed [IN_W:0]    q1_q;
    logic [OUT_W-1:0]        d2_q;
    logic [OUT_W-1:0]        mem [FIFO_DEPTH];
    logic [AW-1:0]           wr_q, rd_q;
    logic [LW-1:0]           level_q, level_d;
    logic [15:0]             sat_cnt_q, sat_cnt_d;
    logic                    drop_d, sat2_d, pop, full, wr, drop_ev;
    logic signed [IN_W:0]    sum_w;
    logic [OUT_W-1:0]        d2_d;

    // One extra bit keeps the rounding add from wrapping near the positive limit.
    assign sum_w = $signed({bus.i_result[IN_W-1], bus.i_result}) + RND;

    always_comb begin
        sat2_d    = (q1_q > MAXV) || (q1_q < MINV);
        d2_d      = (q1_q > MAXV) ? {1'b0, {(OUT_W-1){1'b1}}} :
                    (q1_q < MINV) ? {1'b1, {(OUT_W-1){1'b0}}} : q1_q[OUT_W-1:0];
        pop       = bus.o_valid & bus.i_ready;
        full      = level_q == LW'(FIFO_DEPTH);
        wr        = v2_q & (~full | pop);
        drop_ev   = v2_q & full & ~pop;
        level_d   = level_q + LW'(wr) - LW'(pop);
        sat_cnt_d = bus.i_clear_status ? 16'd0 :
                    (v2_q & sat2_q & ~&sat_cnt_q) ? sat_cnt_q + 16'd1 : sat_cnt_q;
        drop_d    = bus.i_clear_status ? 1'b0 : drop_q | drop_ev;
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            wr_q      <= '0;
            rd_q      <= '0;
            level_q   <= '0;
            sat_cnt_q <= '0;
            drop_q    <= 1'b0;
        end else begin
            v1_q      <= bus.i_ce;
            v2_q      <= v1_q;
            wr_q      <= wr_q + AW'(wr);
            rd_q      <= rd_q + AW'(pop);
            level_q   <= level_d;
            sat_cnt_q <= sat_cnt_d;
            drop_q    <= drop_d;
        end
    end

    // Datapath and storage carry no reset; the valids and pointers qualify them.
    always_ff @(posedge clk) begin
        q1_q   <= sum_w >>> SHIFT;
        d2_q   <= d2_d;
        sat2_q <= sat2_d;
        if (wr) mem[wr_q] <= d2_q;
    end

    assign bus.o_valid   = level_q != '0;
    assign bus.o_data    = bus.o_valid ? mem[rd_q] : '0;
    assign bus.o_level   = level_q;
    assign bus.o_sat_cnt = sat_cnt_q;
    assign bus.o_drop    = drop_q;
endmodule

// File: tb/tb_fir_result_quantizer.sv
// tb_fir_result_quantizer: directed and random stimulus checked against a queue-based
// model of rounding, saturation, 2-cycle latency and the 8-entry FIFO.
module tb_fir_result_quantizer;
    logic clk = 1'b0;
    logic i_reset;
    int   n_assert = 0;
    int   n_fail = 0;

    typedef struct {bit v; longint x;} h_t;
    h_t          hist[$];
    logic [15:0] mq[$];
    int          msat;
    bit          mdrop;

    fir_result_quantizer_if #(.IN_W(39), .OUT_W(16), .FIFO_DEPTH(8)) bus ();
    fir_result_quantizer #(.IN_W(39), .OUT_W(16), .SHIFT(15), .FIFO_DEPTH(8)) dut (
        .clk(clk), .i_reset(i_reset), .bus(bus.slave)
    );

    always #5 clk = ~clk;

    function automatic longint quant(input longint x, output bit sat);
        longint s = x + 16384;
        longint q = s / 32768;
        if (s < 0 && (s % 32768) != 0) q = q - 1;
        sat = (q > 32767) || (q < -32768);
        return (q > 32767) ? 32767 : (q < -32768) ? -32768 : q;
    endfunction

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input bit rst, input bit ce, input longint x, input bit rdy, input bit clr);
        bit     pop, arr, s, drop_ev;
        longint ax, r;
        i_reset = rst;
        bus.i_ce = ce;
        bus.i_result = 39'(x);
        bus.i_ready = rdy;
        bus.i_clear_status = clr;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            hist.delete();
            msat = 0;
            mdrop = 0;
        end else begin
            pop = mq.size() > 0 && rdy;
            arr = 0;
            ax = 0;
            s = 0;
            drop_ev = 0;
            if (hist.size() >= 2) begin
                arr = hist[hist.size()-2].v;
                ax = hist[hist.size()-2].x;
            end
            if (pop) void'(mq.pop_front());
            if (arr) begin
                r = quant(ax, s);
                if (mq.size() == 8) drop_ev = 1;
                else mq.push_back(16'(r));
            end
            if (clr) msat = 0;
            else if (arr && s && msat != 65535) msat++;
            if (clr) mdrop = 0;
            else if (drop_ev) mdrop = 1;
            hist.push_back('{ce, x});
            if (hist.size() > 2) void'(hist.pop_front());
        end
        #1;
        chk("valid", longint'(bus.o_valid), longint'(mq.size() > 0));
        chk("data", longint'(bus.o_data), mq.size() > 0 ? longint'(mq[0]) : 0);
        chk("level", longint'(bus.o_level), longint'(mq.size()));
        chk("sat_cnt", longint'(bus.o_sat_cnt), longint'(msat));
        chk("drop", longint'(bus.o_drop), longint'(mdrop));
    endtask

    initial begin
        longint rv[5] = '{16384, -16384, -16385, 49151, 49152};
        logic signed [38:0] rnd;
        step(1, 0, 0, 0, 0);
        step(1, 1, 98304, 0, 0);
        chk("rst_valid", longint'(bus.o_valid), 0);
        chk("rst_data", longint'(bus.o_data), 0);
        chk("rst_level", longint'(bus.o_level), 0);
        chk("rst_sat", longint'(bus.o_sat_cnt), 0);
        chk("rst_drop", longint'(bus.o_drop), 0);
        // single sample latency
        step(0, 1, 98304, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        chk("lat_valid", longint'(bus.o_valid), 1);
        chk("lat_data", longint'(bus.o_data), 3);
        step(0, 0, 0, 1, 0);
        chk("lat_gone", longint'(bus.o_valid), 0);
        // rounding cases, back-to-back
        foreach (rv[i]) step(0, 1, rv[i], 1, 0);
        repeat (3) step(0, 0, 0, 1, 0);
        // saturation
        step(0, 1, 64'sd1 <<< 31, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        chk("sat_hi", longint'(bus.o_data), 32767);
        step(0, 1, -(64'sd1 <<< 31), 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        chk("sat_lo", longint'(bus.o_data), 32768);
        step(0, 0, 0, 1, 0);
        chk("sat_cnt2", longint'(bus.o_sat_cnt), 2);
        step(0, 0, 0, 1, 1);
        chk("sat_clr", longint'(bus.o_sat_cnt), 0);
        // backpressure with overflow
        for (int k = 1; k <= 10; k++) step(0, 1, longint'(k) <<< 15, 0, 0);
        repeat (2) step(0, 0, 0, 0, 0);
        chk("bp_level", longint'(bus.o_level), 8);
        chk("bp_drop", longint'(bus.o_drop), 1);
        for (int k = 1; k <= 8; k++) begin
            chk("drain", longint'(bus.o_data), k);
            step(0, 0, 0, 1, 0);
        end
        chk("drained", longint'(bus.o_valid), 0);
        // full FIFO with simultaneous write and pop
        step(0, 0, 0, 0, 1);
        repeat (8) step(0, 1, 1000000, 0, 0);
        repeat (2) step(0, 0, 0, 0, 0);
        step(0, 1, -1000000, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        chk("full_level", longint'(bus.o_level), 8);
        chk("full_drop", longint'(bus.o_drop), 0);
        repeat (3) step(0, 0, 0, 1, 0);
        chk("lvl5", longint'(bus.o_level), 5);
        step(0, 1, 12345678, 0, 0);
        step(0, 1, 23456789, 0, 0);
        step(1, 1, 34567890, 0, 0);
        chk("mid_rst_level", longint'(bus.o_level), 0);
        chk("mid_rst_valid", longint'(bus.o_valid), 0);
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 1, 0);
            chk("no_inflight", longint'(bus.o_valid), 0);
        end
        // random traffic
        for (int k = 0; k < 600; k++) begin
            rnd = $signed(39'({$urandom, $urandom})) >>> $urandom_range(0, 30);
            step($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0, longint'(rnd),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
